// File: rtl/imagem_pixel_streamer.sv
// Streams a programmed run of image-RAM pixels as an Avalon-ST packet with
// sop/eop and end-of-line markers, controlled through a 4-word CSR slave.
module imagem_pixel_streamer #(
  parameter int IMG_WORDS  = 58368,
  parameter int LINE_LEN   = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  csr_address,
  input  logic        csr_write,
  input  logic        csr_read,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [15:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  input  logic [7:0]  mem_readdata,
  output logic [7:0]  src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_sop,
  output logic        src_eop,
  output logic        src_eol
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  localparam int LW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [16:0]   IMG_WORDS_W = 17'(IMG_WORDS);
  localparam logic [LW-1:0] LINE_LAST   = LW'(LINE_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [15:0]   base_q, count_q, xfer_count, rd_addr, issued, emitted;
  logic [LW-1:0] line_pos;
  logic          done_q, inflight, busy, issue;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;
  logic [16:0]   addr_inc;
  logic          ctrl_wr, start_req, abort_req, push, pop, last_beat;

  wire unused_wdata = ^csr_writedata[31:16];

  assign ctrl_wr   = csr_write && (csr_address == 2'd0);
  assign start_req = ctrl_wr && csr_writedata[0] && (state == IDLE);
  assign abort_req = ctrl_wr && csr_writedata[1] && (state != IDLE);
  assign push      = inflight;
  assign pop       = src_valid && src_ready;
  assign last_beat = (emitted == xfer_count - 16'd1);
  assign addr_inc  = {1'b0, rd_addr} + 17'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (abort_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_req && (count_q != 16'd0)) state_nxt = RUN;
        RUN:     if (issue && (issued == xfer_count - 16'd1)) state_nxt = DRAIN;
        DRAIN:   if (pop && last_beat) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Credit counts beats in the FIFO plus the one read whose data is on the bus.
  always_comb begin
    busy           = (state != IDLE);
    issue          = (state == RUN) && (CW'(occ) + CW'(inflight) < CW'(FIFO_DEPTH))
                     && (issued < xfer_count);
    mem_chipselect = issue;
    mem_address    = rd_addr;
    mem_write      = 1'b0;
    src_valid      = (occ != '0);
    src_data       = src_valid ? fifo_mem[rd_ptr] : 8'd0;
    src_sop        = src_valid && (emitted == 16'd0);
    src_eop        = src_valid && last_beat;
    src_eol        = src_valid && (line_pos == LINE_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q       <= '0;
      count_q      <= '0;
      xfer_count   <= '0;
      done_q       <= 1'b0;
      rd_addr      <= '0;
      issued       <= '0;
      emitted      <= '0;
      line_pos     <= '0;
      inflight     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      csr_readdata <= '0;
    end else begin
      if (csr_write) begin
        case (csr_address)
          2'd1:    if (csr_writedata[1]) done_q <= 1'b0;
          2'd2:    base_q  <= csr_writedata[15:0];
          2'd3:    count_q <= csr_writedata[15:0];
          default: ;
        endcase
      end

      // An empty transfer completes immediately; otherwise START clears DONE.
      if (start_req) begin
        done_q     <= (count_q == 16'd0);
        xfer_count <= count_q;
        rd_addr    <= base_q;
        issued     <= '0;
        emitted    <= '0;
        line_pos   <= '0;
      end

      if (issue) begin
        issued  <= issued + 16'd1;
        rd_addr <= (addr_inc >= IMG_WORDS_W) ? 16'd0 : addr_inc[15:0];
      end
      inflight <= issue;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        emitted  <= emitted + 16'd1;
        line_pos <= (line_pos == LINE_LAST) ? '0 : line_pos + LW'(1);
        if (last_beat) done_q <= 1'b1;
      end
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);

      // Abort drops buffered beats and the read still returning from the RAM.
      if (abort_req) begin
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        occ      <= '0;
      end

      if (csr_read) begin
        case (csr_address)
          2'd1:    csr_readdata <= {30'd0, done_q, busy};
          2'd2:    csr_readdata <= {16'd0, base_q};
          2'd3:    csr_readdata <= {16'd0, count_q};
          default: csr_readdata <= '0;
        endcase
      end
    end
  end

  // NOTE: the FIFO storage has no reset; occupancy and pointers alone decide
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_readdata;
  end
endmodule
